// File: rtl/ecdsa_vector_sequencer.sv
// Streams ECDSA verify vectors from a ROM into the verify engine and scores each verdict.
// Optional engine watchdog: define ECDSA_SEQ_TIMEOUT_EN.
module ecdsa_vector_sequencer #(
  parameter int OP_W        = 521,
  parameter int IDX_W       = 16,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [IDX_W-1:0] num_vec,
  input  logic             stop_on_fail,
  output logic             busy,
  output logic             done,
  output logic             rom_rd,
  output logic [IDX_W-1:0] rom_addr,
  input  logic             rom_valid,
  input  logic [OP_W-1:0]  rom_qx,
  input  logic [OP_W-1:0]  rom_qy,
  input  logic [OP_W-1:0]  rom_hash,
  input  logic [OP_W-1:0]  rom_r,
  input  logic [OP_W-1:0]  rom_s,
  input  logic             rom_exp,
  output logic             eng_start,
  output logic [OP_W-1:0]  eng_qx,
  output logic [OP_W-1:0]  eng_qy,
  output logic [OP_W-1:0]  eng_hash,
  output logic [OP_W-1:0]  eng_r,
  output logic [OP_W-1:0]  eng_s,
  input  logic             eng_done,
  input  logic             eng_valid,
  output logic             eng_abort,
  output logic [IDX_W-1:0] pass_cnt,
  output logic [IDX_W-1:0] fail_cnt,
  output logic [IDX_W-1:0] timeout_cnt,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_LAUNCH, S_WAIT_ENG, S_CHECK, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic             sof_q, sof_d;
  logic             exp_q, exp_d;
  logic             res_q, res_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] pass_q, pass_d;
  logic [IDX_W-1:0] fail_q, fail_d;
  logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
  logic             ff_vld_q, ff_vld_d;
  logic [OP_W-1:0]  qx_q, qx_d, qy_q, qy_d, hash_q, hash_d, r_q, r_d, s_q, s_d;
  logic             timed_out;
  logic             match;
  logic             last_vec;

`ifdef ECDSA_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             to_q, to_d;
  logic [IDX_W-1:0] tmo_q, tmo_d;
  logic             abort_c;
  assign timed_out   = to_q;
  assign eng_abort   = abort_c;
  assign timeout_cnt = tmo_q;
`else
  assign timed_out   = 1'b0;
  assign eng_abort   = 1'b0;
  assign timeout_cnt = '0;
`endif

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign match    = (res_q == exp_q) && !timed_out;
  // Compare one bit wider so idx+1 cannot alias back to zero.
  assign last_vec = ({1'b0, idx_q} + 1'b1) == {1'b0, num_q};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    sof_d     = sof_q;
    exp_d     = exp_q;
    res_d     = res_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ff_idx_d  = ff_idx_q;
    ff_vld_d  = ff_vld_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    hash_d    = hash_q;
    r_d       = r_q;
    s_d       = s_q;
    rom_rd    = 1'b0;
    eng_start = 1'b0;
`ifdef ECDSA_SEQ_TIMEOUT_EN
    wd_d      = wd_q;
    to_d      = to_q;
    tmo_d     = tmo_q;
    abort_c   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) begin
          num_d    = num_vec;
          sof_d    = stop_on_fail;
          idx_d    = '0;
          pass_d   = '0;
          fail_d   = '0;
          ff_idx_d = '0;
          ff_vld_d = 1'b0;
          done_d   = 1'b0;
`ifdef ECDSA_SEQ_TIMEOUT_EN
          tmo_d    = '0;
`endif
          state_d  = (num_vec == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        rom_rd  = 1'b1;
        state_d = S_WAIT_ROM;
      end
      S_WAIT_ROM: begin
        if (rom_valid) begin
          qx_d    = rom_qx;
          qy_d    = rom_qy;
          hash_d  = rom_hash;
          r_d     = rom_r;
          s_d     = rom_s;
          exp_d   = rom_exp;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        eng_start = 1'b1;
`ifdef ECDSA_SEQ_TIMEOUT_EN
        wd_d      = '0;
        to_d      = 1'b0;
`endif
        state_d   = S_WAIT_ENG;
      end
      S_WAIT_ENG: begin
        if (eng_done) begin
          res_d   = eng_valid;
          state_d = S_CHECK;
        end
`ifdef ECDSA_SEQ_TIMEOUT_EN
        // A completion on the expiry cycle still counts as a normal result.
        else if (wd_q == WD_LAST) begin
          abort_c = 1'b1;
          to_d    = 1'b1;
          tmo_d   = sat_inc(tmo_q);
          state_d = S_CHECK;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_CHECK: begin
        if (match) begin
          pass_d = sat_inc(pass_q);
        end else begin
          fail_d = sat_inc(fail_q);
          if (!ff_vld_q) begin
            ff_vld_d = 1'b1;
            ff_idx_d = idx_q;
          end
        end
        idx_d   = sat_inc(idx_q);
        state_d = (last_vec || (!match && sof_q)) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      num_q    <= '0;
      sof_q    <= 1'b0;
      exp_q    <= 1'b0;
      res_q    <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
      ff_idx_q <= '0;
      ff_vld_q <= 1'b0;
      qx_q     <= '0;
      qy_q     <= '0;
      hash_q   <= '0;
      r_q      <= '0;
      s_q      <= '0;
`ifdef ECDSA_SEQ_TIMEOUT_EN
      wd_q     <= '0;
      to_q     <= 1'b0;
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      sof_q    <= sof_d;
      exp_q    <= exp_d;
      res_q    <= res_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ff_idx_q <= ff_idx_d;
      ff_vld_q <= ff_vld_d;
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      hash_q   <= hash_d;
      r_q      <= r_d;
      s_q      <= s_d;
`ifdef ECDSA_SEQ_TIMEOUT_EN
      wd_q     <= wd_d;
      to_q     <= to_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = done_q;
  assign rom_addr       = rom_rd ? idx_q : '0;
  assign eng_qx         = qx_q;
  assign eng_qy         = qy_q;
  assign eng_hash       = hash_q;
  assign eng_r          = r_q;
  assign eng_s          = s_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_ecdsa_vector_sequencer.sv
// Directed bench for ecdsa_vector_sequencer with behavioural ROM and engine models.
module tb_ecdsa_vector_sequencer;
  localparam int OP_W = 32;
  localparam int IDX_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic [IDX_W-1:0] num_vec = '0;
  logic stop_on_fail = 1'b0;
  logic busy, done, rom_rd, eng_start, eng_abort, first_fail_vld;
  logic [IDX_W-1:0] rom_addr, pass_cnt, fail_cnt, timeout_cnt, first_fail_idx;
  logic rom_valid = 1'b0;
  logic [OP_W-1:0] rom_qx = '0, rom_qy = '0, rom_hash = '0, rom_r = '0, rom_s = '0;
  logic rom_exp = 1'b0;
  logic [OP_W-1:0] eng_qx, eng_qy, eng_hash, eng_r, eng_s;
  logic eng_done = 1'b0;
  logic eng_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rom_lat = 2;
  int eng_lat = 10;
  bit eng_mute = 0;
  bit exp_tab [16];
  bit flip_tab [16];
  int cur = 0;
  int addr_log [$];
  int start_cyc = 0;
  int abort_cyc = 0;
  int abort_cnt = 0;

  ecdsa_vector_sequencer #(.OP_W(OP_W), .IDX_W(IDX_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .num_vec(num_vec), .stop_on_fail(stop_on_fail),
    .busy(busy), .done(done), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_valid(rom_valid),
    .rom_qx(rom_qx), .rom_qy(rom_qy), .rom_hash(rom_hash), .rom_r(rom_r), .rom_s(rom_s),
    .rom_exp(rom_exp), .eng_start(eng_start), .eng_qx(eng_qx), .eng_qy(eng_qy),
    .eng_hash(eng_hash), .eng_r(eng_r), .eng_s(eng_s), .eng_done(eng_done),
    .eng_valid(eng_valid), .eng_abort(eng_abort), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .timeout_cnt(timeout_cnt), .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ROM model: answers each read rom_lat negedges later with an index-derived pattern.
  initial begin
    forever begin
      @(negedge clk);
      if (rom_rd === 1'b1) begin
        cur = int'(rom_addr);
        addr_log.push_back(cur);
        repeat (rom_lat - 1) @(negedge clk);
        rom_valid = 1'b1;
        rom_qx    = 32'h1000 + cur;
        rom_qy    = 32'h2000 + cur;
        rom_hash  = 32'h3000 + cur;
        rom_r     = 32'h4000 + cur;
        rom_s     = 32'h5000 + cur;
        rom_exp   = exp_tab[cur];
        @(negedge clk);
        rom_valid = 1'b0;
      end
    end
  end

  // Engine model: verdict is the expected result, optionally flipped per vector.
  initial begin
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        start_cyc = cyc;
        checks++;
        if ({eng_qx, eng_qy, eng_hash, eng_r, eng_s} !==
            {32'h1000 + cur, 32'h2000 + cur, 32'h3000 + cur, 32'h4000 + cur, 32'h5000 + cur}) begin
          errors++;
          $display("FAIL operands vec %0d: got qx=%h s=%h want qx=%h s=%h",
                   cur, eng_qx, eng_s, 32'h1000 + cur, 32'h5000 + cur);
        end
        if (!eng_mute) begin
          repeat (eng_lat - 1) @(negedge clk);
          eng_done  = 1'b1;
          eng_valid = exp_tab[cur] ^ flip_tab[cur];
          @(negedge clk);
          eng_done  = 1'b0;
          eng_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (eng_abort === 1'b1) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
    end
  end

  task automatic start_run(input int n, input bit sof);
    @(negedge clk);
    num_vec = IDX_W'(n);
    stop_on_fail = sof;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (done !== 1'b1 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done timeout: got done=%b want 1", name, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rom_rd, eng_start, eng_abort, first_fail_vld} !== 6'b0 ||
        {pass_cnt, fail_cnt, timeout_cnt, first_fail_idx, rom_addr} !== '0 ||
        {eng_qx, eng_qy, eng_hash, eng_r, eng_s} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b done=%b pass=%0d fail=%0d qx=%h want all 0",
               busy, done, pass_cnt, fail_cnt, eng_qx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_pass;
    exp_tab[0] = 1; exp_tab[1] = 0; exp_tab[2] = 1;
    foreach (flip_tab[i]) flip_tab[i] = 0;
    addr_log.delete();
    start_run(3, 0);
    checks++;
    if (busy !== 1'b1 || rom_rd !== 1'b1 || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL all_pass first cycle: got busy=%b rom_rd=%b addr=%0d want 1 1 0",
               busy, rom_rd, rom_addr);
    end
    wait_done("all_pass");
    checks++;
    if (pass_cnt !== 16'd3 || fail_cnt !== 16'd0 || busy !== 1'b0 || first_fail_vld !== 1'b0) begin
      errors++;
      $display("FAIL all_pass counts: got pass=%0d fail=%0d busy=%b ffv=%b want 3 0 0 0",
               pass_cnt, fail_cnt, busy, first_fail_vld);
    end
    checks++;
    if (addr_log.size() != 3 || addr_log[0] != 0 || addr_log[1] != 1 || addr_log[2] != 2) begin
      errors++;
      $display("FAIL all_pass addr seq: got %p want '{0,1,2}", addr_log);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass_cnt !== 16'd3 || timeout_cnt !== 16'd0) begin
      errors++;
      $display("FAIL all_pass hold: got done=%b pass=%0d tmo=%0d want 1 3 0",
               done, pass_cnt, timeout_cnt);
    end
  endtask

  task automatic test_mismatch;
    exp_tab[0] = 0; exp_tab[1] = 1; exp_tab[2] = 1; exp_tab[3] = 0;
    foreach (flip_tab[i]) flip_tab[i] = 0;
    flip_tab[1] = 1;
    eng_lat = 4;
    rom_lat = 3;
    addr_log.delete();
    start_run(4, 0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mismatch done cleared: got %b want 0", done);
    end
    wait_done("mismatch");
    checks++;
    if (pass_cnt !== 16'd3 || fail_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mismatch counts: got pass=%0d fail=%0d want 3 1", pass_cnt, fail_cnt);
    end
    checks++;
    if (first_fail_vld !== 1'b1 || first_fail_idx !== 16'd1) begin
      errors++;
      $display("FAIL mismatch first_fail: got vld=%b idx=%0d want 1 1",
               first_fail_vld, first_fail_idx);
    end
  endtask

  task automatic test_stop_on_fail;
    for (int i = 0; i < 10; i++) begin
      exp_tab[i] = i[0];
      flip_tab[i] = 0;
    end
    flip_tab[2] = 1;
    flip_tab[5] = 1;
    eng_lat = 6;
    rom_lat = 2;
    addr_log.delete();
    start_run(10, 1);
    wait_done("stop_on_fail");
    checks++;
    if (pass_cnt !== 16'd2 || fail_cnt !== 16'd1 || first_fail_idx !== 16'd2) begin
      errors++;
      $display("FAIL stop counts: got pass=%0d fail=%0d ffi=%0d want 2 1 2",
               pass_cnt, fail_cnt, first_fail_idx);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (addr_log.size() != 3) begin
      errors++;
      $display("FAIL stop rom reads: got %0d reads want 3", addr_log.size());
    end
  endtask

  task automatic test_empty_and_strobes;
    addr_log.delete();
    start_run(0, 0);
    checks++;
    if (rom_rd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty strobes: got rom_rd=%b busy=%b want 0 0", rom_rd, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || first_fail_vld !== 1'b0) begin
      errors++;
      $display("FAIL empty done: got done=%b pass=%0d fail=%0d ffv=%b want 1 0 0 0",
               done, pass_cnt, fail_cnt, first_fail_vld);
    end
    eng_done = 1'b1; eng_valid = 1'b1; rom_valid = 1'b1;
    @(negedge clk);
    eng_done = 1'b0; eng_valid = 1'b0; rom_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || busy !== 1'b0 ||
        done !== 1'b1 || addr_log.size() != 0) begin
      errors++;
      $display("FAIL idle strobes: got pass=%0d fail=%0d busy=%b done=%b reads=%0d want 0 0 0 1 0",
               pass_cnt, fail_cnt, busy, done, addr_log.size());
    end
  endtask

  task automatic test_reset_mid_run;
    int c = 0;
    exp_tab[0] = 1; exp_tab[1] = 1;
    flip_tab[0] = 0; flip_tab[1] = 0;
    eng_lat = 20;
    start_run(2, 0);
    while (eng_start !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (eng_start !== 1'b1) begin
      errors++;
      $display("FAIL midrun launch: got eng_start=%b want 1", eng_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, rom_rd, eng_start, first_fail_vld} !== 5'b0 ||
        {pass_cnt, fail_cnt, eng_qx, eng_s} !== '0) begin
      errors++;
      $display("FAIL midrun reset: got busy=%b done=%b pass=%0d qx=%h want all 0",
               busy, done, pass_cnt, eng_qx);
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midrun late done: got busy=%b done=%b pass=%0d fail=%0d want 0 0 0 0",
               busy, done, pass_cnt, fail_cnt);
    end
  endtask

`ifdef ECDSA_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    exp_tab[0] = 1;
    flip_tab[0] = 0;
    eng_mute = 1;
    abort_cnt = 0;
    start_run(1, 0);
    wait_done("timeout");
    checks++;
    if (abort_cnt != 1 || abort_cyc - start_cyc != 16) begin
      errors++;
      $display("FAIL timeout abort: got pulses=%0d delay=%0d want 1 16",
               abort_cnt, abort_cyc - start_cyc);
    end
    checks++;
    if (timeout_cnt !== 16'd1 || fail_cnt !== 16'd1 || pass_cnt !== 16'd0) begin
      errors++;
      $display("FAIL timeout counts: got tmo=%0d fail=%0d pass=%0d want 1 1 0",
               timeout_cnt, fail_cnt, pass_cnt);
    end
    eng_mute = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_all_pass;
    test_mismatch;
    test_stop_on_fail;
    test_empty_and_strobes;
    test_reset_mid_run;
`ifdef ECDSA_SEQ_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
